pipeline_controller: RTL and testbench

PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

---
 rtl/pipeline_controller.sv | 124 ++++++++++++
 tb/tb_pipeline_controller.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// Run/step/halt sequencer for a 5-stage pipeline: drives stage enables, load-use bubbles and branch flushes.
// Enables are combinational from state and inputs; state, drain counter and cycle counter are registered.
module pipeline_controller #(
    parameter int DRAIN_CYCLES = 4,
    parameter int COUNTER_SIZE = 32
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_run,
    input  logic                    i_step,
    input  logic                    i_halt_op,
    input  logic                    i_ex_mem_read,
    input  logic                    i_next_pc_src,
    input  logic [4:0]              i_id_rs,
    input  logic [4:0]              i_id_rt,
    input  logic [4:0]              i_ex_rt,
    output logic                    o_pc_enable,
    output logic                    o_if_id_enable,
    output logic                    o_if_id_flush,
    output logic                    o_id_ex_enable,
    output logic                    o_ctr_reg_src,
    output logic                    o_halted,
    output logic [2:0]              o_state,
    output logic [COUNTER_SIZE-1:0] o_cycle_count
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN    = 3'd1,
        STEP   = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [DCW-1:0]   drain_cnt;
    logic             hazard;
    logic             enter_drain;

    assign hazard = i_ex_mem_read && (i_ex_rt != 5'd0) &&
                    ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));

    // A stalled HALT is not yet committed; it is re-seen next cycle.
    assign enter_drain = i_halt_op && !hazard;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        o_pc_enable    = 1'b0;
        o_if_id_enable = 1'b0;
        o_if_id_flush  = 1'b0;
        o_id_ex_enable = 1'b0;
        o_ctr_reg_src  = 1'b0;
        o_halted       = 1'b0;
        case (state)
            IDLE: begin
                if (i_run) begin
                    state_next = RUN;
                end else if (i_step) begin
                    state_next = STEP;
                end
            end
            RUN, STEP: begin
                o_id_ex_enable = 1'b1;
                if (hazard) begin
                    o_ctr_reg_src = 1'b1;
                end else begin
                    o_pc_enable    = 1'b1;
                    o_if_id_enable = 1'b1;
                    o_if_id_flush  = i_next_pc_src;
                end
                if (enter_drain) begin
                    state_next = DRAIN;
                end else if (state == STEP || !i_run) begin
                    state_next = IDLE;
                end
            end
            DRAIN: begin
                o_id_ex_enable = 1'b1;
                o_ctr_reg_src  = 1'b1;
                if (drain_cnt == '0) begin
                    state_next = HALTED;
                end
            end
            HALTED: begin
                o_halted = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            drain_cnt <= '0;
        end else if ((state == RUN || state == STEP) && enter_drain) begin
            drain_cnt <= DCW'(DRAIN_CYCLES - 1);
        end else if (state == DRAIN && drain_cnt != '0) begin
            drain_cnt <= drain_cnt - DCW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_cycle_count <= '0;
        end else if (state == RUN || state == STEP || state == DRAIN) begin
            o_cycle_count <= o_cycle_count + COUNTER_SIZE'(1);
        end
    end

    assign o_state = state;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller with a per-cycle reference model and literal spot checks.
module tb_pipeline_controller;

    localparam int DC = 4;

    logic        clk;
    logic        rst;
    logic        run, step, halt_op, ex_mem_read, next_pc_src;
    logic [4:0]  id_rs, id_rt, ex_rt;
    logic        pc_en, if_id_en, if_id_flush, id_ex_en, ctr_src, halted;
    logic [2:0]  state;
    logic [31:0] cnt;

    int checks = 0;
    int errors = 0;

    pipeline_controller #(.DRAIN_CYCLES(DC), .COUNTER_SIZE(32)) dut (
        .i_clk(clk), .i_reset(rst),
        .i_run(run), .i_step(step), .i_halt_op(halt_op),
        .i_ex_mem_read(ex_mem_read), .i_next_pc_src(next_pc_src),
        .i_id_rs(id_rs), .i_id_rt(id_rt), .i_ex_rt(ex_rt),
        .o_pc_enable(pc_en), .o_if_id_enable(if_id_en), .o_if_id_flush(if_id_flush),
        .o_id_ex_enable(id_ex_en), .o_ctr_reg_src(ctr_src), .o_halted(halted),
        .o_state(state), .o_cycle_count(cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 run, 2 step, 3 drain, 4 halted; m_left = drain cycles still to spend.
    int          m_state;
    int          m_left;
    logic [31:0] m_cnt;

    function automatic bit model_hazard();
        return ex_mem_read && (ex_rt != 5'd0) && (ex_rt == id_rs || ex_rt == id_rt);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= 0;
            m_left  <= 0;
            m_cnt   <= 32'd0;
        end else begin
            if (m_state >= 1 && m_state <= 3) m_cnt <= m_cnt + 32'd1;
            case (m_state)
                0: m_state <= run ? 1 : (step ? 2 : 0);
                1, 2: begin
                    if (halt_op && !model_hazard()) begin
                        m_state <= 3;
                        m_left  <= DC;
                    end else if (m_state == 2 || !run) begin
                        m_state <= 0;
                    end
                end
                3: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) m_state <= 4;
                end
                default: ;
            endcase
        end
    end

    // {pc, if_id, flush, id_ex, ctr_reg_src, halted}
    function automatic logic [5:0] model_outs();
        if (m_state == 1 || m_state == 2)
            return model_hazard() ? 6'b000110 : {1'b1, 1'b1, next_pc_src, 1'b1, 1'b0, 1'b0};
        if (m_state == 3) return 6'b000110;
        if (m_state == 4) return 6'b000001;
        return 6'b000000;
    endfunction

    always @(negedge clk) begin
        chk("outputs", {26'd0, pc_en, if_id_en, if_id_flush, id_ex_en, ctr_src, halted},
            {26'd0, model_outs()});
        chk("state", {29'd0, state}, m_state[31:0]);
        chk("cycle_count", cnt, m_cnt);
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        run = 0; step = 0; halt_op = 0; ex_mem_read = 0; next_pc_src = 0;
        id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        cyc(2);
        rst = 0;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        do_reset();
        chk("reset_state", {29'd0, state}, 32'd0);
        chk("reset_count", cnt, 32'd0);

        // Continuous run: RUN after one edge, ten counted cycles after eleven edges.
        run = 1;
        cyc(1);
        chk("run_entry", {29'd0, state}, 32'd1);
        cyc(10);
        chk("run_count10", cnt, 32'd10);
        chk("run_enables", {29'd0, pc_en, if_id_en, id_ex_en}, 32'h7);

        // Load-use stall on rs, then back to normal.
        ex_mem_read = 1; ex_rt = 5'd5; id_rs = 5'd5; id_rt = 5'd9;
        #1;
        chk("stall_bubble", {29'd0, pc_en, if_id_en, ctr_src}, 32'd1);
        cyc(1);
        ex_mem_read = 0;
        #1;
        chk("stall_release", {31'd0, pc_en}, 32'd1);
        // Load to r0 is never a hazard; load matching rt is.
        ex_mem_read = 1; ex_rt = 5'd0; id_rs = 5'd0;
        cyc(1);
        ex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7;
        cyc(1);
        ex_mem_read = 0; id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;

        // Branch flush suppressed by a simultaneous hazard, taken next cycle.
        next_pc_src = 1; ex_mem_read = 1; ex_rt = 5'd3; id_rt = 5'd3;
        #1;
        chk("flush_hazard", {31'd0, if_id_flush}, 32'd0);
        cyc(1);
        ex_mem_read = 0;
        #1;
        chk("flush_taken", {31'd0, if_id_flush}, 32'd1);
        cyc(1);
        next_pc_src = 0;

        // HALT blocked by hazard stays in RUN.
        halt_op = 1; ex_mem_read = 1; ex_rt = 5'd3; id_rt = 5'd3;
        cyc(1);
        chk("halt_hazard", {29'd0, state}, 32'd1);
        halt_op = 0; ex_mem_read = 0; ex_rt = 5'd0; id_rt = 5'd0;
        run = 0;
        cyc(1);
        chk("run_to_idle", {29'd0, state}, 32'd0);

        // Three isolated step pulses.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step = 1;
            cyc(1);
            step = 0;
            chk("step_state", {29'd0, state}, 32'd2);
            cyc(3);
        end
        chk("step_count3", cnt, 32'd3);
        // Held step alternates STEP/IDLE.
        step = 1;
        cyc(4);
        step = 0;
        cyc(1);
        chk("step_held_count", cnt, 32'd5);

        // STEP with HALT enters DRAIN.
        do_reset();
        step = 1; halt_op = 1;
        cyc(1);
        step = 0;
        cyc(1);
        halt_op = 0;
        chk("step_halt_drain", {29'd0, state}, 32'd3);

        // Halt from RUN: four DRAIN cycles, then terminal HALTED.
        do_reset();
        run = 1;
        cyc(1);
        halt_op = 1;
        cyc(1);
        halt_op = 0;
        chk("drain_entry", {29'd0, state, ctr_src}, 32'h7);
        cyc(3);
        chk("drain_last", {29'd0, state}, 32'd3);
        cyc(1);
        chk("halted", {28'd0, state, halted}, 32'h9);
        chk("halted_count", cnt, 32'd5);
        for (int i = 0; i < 6; i++) begin
            run = i[0]; step = ~i[0]; halt_op = i[1];
            cyc(1);
        end
        chk("halted_sticky", {29'd0, state}, 32'd4);
        clear_inputs();

        // Asynchronous reset in the 2nd DRAIN cycle.
        do_reset();
        run = 1;
        cyc(1);
        halt_op = 1;
        cyc(1);
        halt_op = 0;
        cyc(1);
        chk("drain2_state", {29'd0, state}, 32'd3);
        #2;
        rst = 1;
        #1;
        chk("async_reset", {cnt[19:0], 3'd0, pc_en, if_id_en, if_id_flush, id_ex_en, ctr_src, halted, state},
            32'd0);
        cyc(2);
        rst = 0;
        run = 1;
        cyc(1);
        chk("post_reset_run", {29'd0, state}, 32'd1);
        run = 0;
        cyc(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
